// File: rtl/crypt_pkg.sv
// Types and constants shared by the encrypt-side and decrypt-side round sequencing logic.
package crypt_pkg;

   localparam int NUM_ROUNDS_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_KEY,
      ST_LOAD,
      ST_ROUND,
      ST_DONE
   } inv_seq_state_t;

endpackage

// File: rtl/inv_round_sequencer_if.sv
// Controller / key-RAM / inverse-datapath signals around the inverse round sequencer.
interface inv_round_sequencer_if #(
   parameter int CNT_W = 5
);

   logic             start;
   logic             key_ready;
   logic             stall;
   logic             abort;
   logic [CNT_W-1:0] round_key_addr;
   logic             round_en;
   logic [CNT_W-1:0] round_idx;
   logic             first_round;
   logic             final_round;
   logic             busy;
   logic             done;

   modport master (
      output start, key_ready, stall, abort,
      input  round_key_addr, round_en, round_idx, first_round, final_round, busy, done
   );

   modport slave (
      input  start, key_ready, stall, abort,
      output round_key_addr, round_en, round_idx, first_round, final_round, busy, done
   );

endinterface

// File: rtl/round_down_counter.sv
// Loadable down counter that holds at zero instead of wrapping; drives the round-key read address.
module round_down_counter #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/inv_round_sequencer.sv
// Walks round keys NUM_ROUNDS..0 for the inverse cipher, reading each key one cycle before its round strobe.
//  state    | meaning
//  IDLE     | waiting for start
//  WAIT_KEY | start seen, key schedule not yet complete
//  LOAD     | key NUM_ROUNDS read address presented to RAM
//  ROUND    | issuing rounds; stall holds address and index
//  DONE     | one-cycle completion pulse
module inv_round_sequencer
   import crypt_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
   parameter int CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   inv_round_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS);

   inv_seq_state_t   state_d, state_q;
   logic             round_en_d, round_en_q;
   logic [CNT_W-1:0] idx_d, idx_q;
   logic             first_d, first_q;
   logic             final_d, final_q;
   logic             busy_d, busy_q;
   logic             done_d, done_q;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_en;
   logic [CNT_W-1:0] addr;
   logic             addr_zero;

   round_down_counter #(.CNT_W(CNT_W)) u_addr_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .value    (addr),
      .zero     (addr_zero)
   );

   always_comb begin
      state_d      = state_q;
      round_en_d   = 1'b0;
      idx_d        = idx_q;
      done_d       = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_en       = 1'b0;

      if (bus.abort) begin
         state_d  = ST_IDLE;
         idx_d    = '0;
         cnt_load = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.key_ready) begin
                     state_d      = ST_LOAD;
                     cnt_load     = 1'b1;
                     cnt_load_val = LAST_IDX;
                  end else begin
                     state_d = ST_WAIT_KEY;
                  end
               end
            end
            ST_WAIT_KEY: begin
               if (bus.key_ready) begin
                  state_d      = ST_LOAD;
                  cnt_load     = 1'b1;
                  cnt_load_val = LAST_IDX;
               end
            end
            ST_LOAD: begin
               state_d    = ST_ROUND;
               round_en_d = 1'b1;
               idx_d      = addr;
               cnt_en     = 1'b1;
            end
            ST_ROUND: begin
               // Key 0 round is on the datapath now; nothing left to issue.
               if (round_en_q && (idx_q == '0)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (!bus.stall) begin
                  round_en_d = 1'b1;
                  idx_d      = addr;
                  cnt_en     = !addr_zero;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d  = (state_d != ST_IDLE);
      first_d = round_en_d && (idx_d == LAST_IDX);
      final_d = round_en_d && (idx_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         round_en_q <= 1'b0;
         idx_q      <= '0;
         first_q    <= 1'b0;
         final_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_en_q <= round_en_d;
         idx_q      <= idx_d;
         first_q    <= first_d;
         final_q    <= final_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.round_key_addr = addr;
   assign bus.round_en       = round_en_q;
   assign bus.round_idx      = idx_q;
   assign bus.first_round    = first_q;
   assign bus.final_round    = final_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;

endmodule

// File: tb/tb_inv_round_sequencer.sv
// Directed bench: expected key indices queued at start, consumed by a round_en monitor.
module tb_inv_round_sequencer;

   localparam int NR = 16;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   cyc;
   int   done_cnt;
   int   exp_q[$];

   inv_round_sequencer_if #(.CNT_W(5)) bus ();

   inv_round_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push_full();
      for (int i = NR; i >= 0; i--) exp_q.push_back(i);
   endtask

   task automatic kick();
      cyc       = 0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic step_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic wait_done(input int limit);
      int k;
      k = 0;
      while (bus.done !== 1'b1 && k < limit) begin
         step();
         k++;
      end
      chk("done_seen", bus.done, 1);
   endtask

   // Scoreboard side: every round strobe must consume the next expected key index.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.round_en === 1'b1) begin
            int e;
            total++;
            assert (exp_q.size() != 0)
            else begin
               bad++;
               $error("FAIL round_unexpected observed idx=%0d expected no round (cyc %0d)", bus.round_idx, cyc);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("round_idx", bus.round_idx, e);
               chk("first_round", bus.first_round, (e == NR));
               chk("final_round", bus.final_round, (e == 0));
            end
         end else begin
            chk("first_idle", bus.first_round, 0);
            chk("final_idle", bus.final_round, 0);
         end
         chk("addr_range", (bus.round_key_addr <= NR), 1);
         if (bus.done === 1'b1) done_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      total = 0; bad = 0; cyc = 0; done_cnt = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.key_ready = 1'b0; bus.stall = 1'b0; bus.abort = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("rst_addr", bus.round_key_addr, 0);
      chk("rst_idx", bus.round_idx, 0);
      chk("rst_round_en", bus.round_en, 0);
      chk("rst_first", bus.first_round, 0);
      chk("rst_final", bus.final_round, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);

      // Nominal block: LOAD at 1, rounds 2..18, done at 19.
      bus.key_ready = 1'b1;
      push_full();
      kick();
      chk("nom_load_busy", bus.busy, 1);
      chk("nom_load_addr", bus.round_key_addr, NR);
      chk("nom_load_round_en", bus.round_en, 0);
      step();
      chk("nom_first_at2", bus.first_round, 1);
      chk("nom_addr_at2", bus.round_key_addr, NR - 1);
      step_to(18);
      chk("nom_final_at18", bus.final_round, 1);
      chk("nom_addr_sat", bus.round_key_addr, 0);
      step();
      chk("nom_done_at19", bus.done, 1);
      chk("nom_busy_at19", bus.busy, 1);
      chk("nom_round_en_at19", bus.round_en, 0);
      step();
      chk("nom_done_pulse", bus.done, 0);
      chk("nom_idle_busy", bus.busy, 0);
      chk("nom_queue_empty", exp_q.size(), 0);

      // Reset in the middle of ROUND at idx 9, then a fresh full block.
      push_full();
      kick();
      step_to(9);
      chk("rst_mid_idx9", bus.round_idx, 9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_round_en", bus.round_en, 0);
      chk("rst_mid_addr", bus.round_key_addr, 0);
      chk("rst_mid_idx", bus.round_idx, 0);
      exp_q.delete();
      push_full();
      kick();
      wait_done(40);
      chk("rst_fresh_done_cyc", cyc, 19);
      chk("rst_fresh_queue", exp_q.size(), 0);
      step();

      // Start before the key schedule finishes; key_ready in cycle 5 gives LOAD at 6, done 18 later.
      bus.key_ready = 1'b0;
      push_full();
      kick();
      while (cyc < 5) begin
         chk("wk_busy", bus.busy, 1);
         chk("wk_addr", bus.round_key_addr, 0);
         chk("wk_round_en", bus.round_en, 0);
         step();
      end
      bus.key_ready = 1'b1;
      step();
      chk("wk_load_addr", bus.round_key_addr, NR);
      chk("wk_load_round_en", bus.round_en, 0);
      wait_done(40);
      chk("wk_done_cyc", cyc, 24);
      chk("wk_queue", exp_q.size(), 0);
      step();

      // Three stall cycles while idx 8 is on the datapath.
      push_full();
      kick();
      step_to(10);
      chk("st_idx8", bus.round_idx, 8);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_round_en_low", bus.round_en, 0);
         chk("st_idx_hold", bus.round_idx, 8);
         chk("st_addr_hold", bus.round_key_addr, 7);
      end
      bus.stall = 1'b0;
      step();
      chk("st_resume_idx", bus.round_idx, 7);
      wait_done(40);
      chk("st_done_cyc", cyc, 22);
      chk("st_queue", exp_q.size(), 0);
      step();

      // Abort at idx 4: no further rounds and no done.
      push_full();
      kick();
      step_to(14);
      chk("ab_idx4", bus.round_idx, 4);
      d0 = done_cnt;
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("ab_busy", bus.busy, 0);
      chk("ab_round_en", bus.round_en, 0);
      chk("ab_done", bus.done, 0);
      exp_q.delete();
      for (int i = 0; i < 20; i++) step();
      chk("ab_no_done", done_cnt, d0);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      step();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk("ab_start_busy", bus.busy, 0);
      chk("ab_start_addr", bus.round_key_addr, 0);
      step();
      chk("ab_start_busy2", bus.busy, 0);

      // Start pulses while busy are ignored; stall while key 0 is being read holds the last round.
      push_full();
      d0 = done_cnt;
      kick();
      while (cyc < 17) begin
         bus.start = (cyc % 2 == 1);
         step();
      end
      bus.start = 1'b0;
      chk("s0_idx1", bus.round_idx, 1);
      bus.stall = 1'b1;
      step();
      chk("s0_hold_round_en", bus.round_en, 0);
      chk("s0_hold_addr", bus.round_key_addr, 0);
      step();
      chk("s0_hold_idx", bus.round_idx, 1);
      chk("s0_hold_addr2", bus.round_key_addr, 0);
      bus.stall = 1'b0;
      step();
      chk("s0_final", bus.final_round, 1);
      wait_done(20);
      chk("s0_done_cyc", cyc, 21);
      for (int i = 0; i < 5; i++) step();
      chk("s0_one_done", done_cnt - d0, 1);
      chk("s0_idle", bus.busy, 0);
      chk("s0_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
